ahb_addr_ctrl: RTL

AHB_ADDR_CTRL -- requirements
Module: ahb_addr_ctrl

---
 rtl/ahb_addr_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_addr_ctrl.sv
// AXI-to-AHB address controller: picks the AW or AR FIFO head, drives the AHB
// address phase beat by beat and pops the AXI head when its burst completes.
module ahb_addr_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              h_clk,
  input  logic              h_resetn,
  input  logic              aw_fifo_empty,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [LEN_W-1:0]  aw_len,
  input  logic [2:0]        aw_size,
  input  logic [1:0]        aw_burst,
  output logic              aw_fifo_rd,
  input  logic              ar_fifo_empty,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [LEN_W-1:0]  ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              ar_fifo_rd,
  input  logic [1:0]        h_trans,
  input  logic              h_ready,
  output logic [ADDR_W-1:0] h_addr,
  output logic [2:0]        h_burst,
  output logic [2:0]        h_size,
  output logic              h_write,
  output logic              aw_done_illegal,
  output logic              ar_done_illegal
);

  localparam int BW = LEN_W + 11;

  typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [2:0]        size_q, size_d;
  logic [2:0]        burst_q, burst_d;
  logic              last_wr, last_wr_d;
  logic              rd_wr, rd_rd;

  function automatic logic [2:0] map_burst(input logic [LEN_W-1:0] len, input logic [1:0] burst);
    map_burst = 3'b001;
    if (burst == 2'b10) begin
      if (len == LEN_W'(3))       map_burst = 3'b010;
      else if (len == LEN_W'(7))  map_burst = 3'b100;
      else if (len == LEN_W'(15)) map_burst = 3'b110;
    end else begin
      if (len == '0)              map_burst = 3'b000;
      else if (len == LEN_W'(3))  map_burst = 3'b011;
      else if (len == LEN_W'(7))  map_burst = 3'b101;
      else if (len == LEN_W'(15)) map_burst = 3'b111;
    end
  endfunction

  // INCR bursts may not run past the end of the 1 KB page they start in
  function automatic logic is_illegal(input logic [9:0] addr_lo, input logic [LEN_W-1:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    logic [BW-1:0] bytes, last;
    logic          wrap_ok;
    bytes   = (BW'(len) + BW'(1)) << size;
    last    = BW'(addr_lo) + bytes - BW'(1);
    wrap_ok = (len == LEN_W'(3)) || (len == LEN_W'(7)) || (len == LEN_W'(15));
    is_illegal = (size > 3'd2);
    case (burst)
      2'b01:   is_illegal = is_illegal | (|last[BW-1:10]);
      2'b10:   is_illegal = is_illegal | !wrap_ok;
      default: is_illegal = 1'b1;
    endcase
  endfunction

  // Wrapping bursts only advance the bits inside the (beats << size) window
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0] size, input logic [2:0] hburst);
    logic [ADDR_W-1:0] inc, mask;
    inc = addr + (ADDR_W'(1) << size);
    case (hburst)
      3'b010:  mask = (ADDR_W'(4) << size) - ADDR_W'(1);
      3'b100:  mask = (ADDR_W'(8) << size) - ADDR_W'(1);
      3'b110:  mask = (ADDR_W'(16) << size) - ADDR_W'(1);
      default: mask = '1;
    endcase
    next_addr = (addr & ~mask) | (inc & mask);
  endfunction

  logic              acc, sel_wr, sel_rd, hd_ill;
  logic [ADDR_W-1:0] hd_addr;
  logic [LEN_W-1:0]  hd_len;
  logic [2:0]        hd_size, hd_hburst;
  logic [1:0]        hd_burst;

  assign acc             = h_ready & ((h_trans == 2'b10) | (h_trans == 2'b11));
  assign aw_done_illegal = !aw_fifo_empty && is_illegal(aw_addr[9:0], aw_len, aw_size, aw_burst);
  assign ar_done_illegal = !ar_fifo_empty && is_illegal(ar_addr[9:0], ar_len, ar_size, ar_burst);
  assign sel_wr          = !aw_fifo_empty && (ar_fifo_empty || !last_wr);
  assign sel_rd          = !ar_fifo_empty && !sel_wr;
  assign hd_addr         = sel_wr ? aw_addr  : ar_addr;
  assign hd_len          = sel_wr ? aw_len   : ar_len;
  assign hd_size         = sel_wr ? aw_size  : ar_size;
  assign hd_burst        = sel_wr ? aw_burst : ar_burst;
  assign hd_ill          = sel_wr ? aw_done_illegal : ar_done_illegal;
  assign hd_hburst       = map_burst(hd_len, hd_burst);

  always_ff @(posedge h_clk or negedge h_resetn) begin
    if (!h_resetn) begin
      state    <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      last_wr  <= 1'b0;
    end else begin
      state    <= state_next;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      last_wr  <= last_wr_d;
    end
  end

  always_comb begin
    state_next = state;
    addr_d     = addr_q;
    remain_d   = remain_q;
    size_d     = size_q;
    burst_d    = burst_q;
    last_wr_d  = last_wr;
    rd_wr      = 1'b0;
    rd_rd      = 1'b0;
    h_addr     = addr_q;
    h_size     = size_q;
    h_burst    = burst_q;
    h_write    = 1'b0;
    case (state)
      IDLE: begin
        h_addr  = hd_addr;
        h_size  = hd_size;
        h_burst = hd_hburst;
        h_write = sel_wr;
        if (sel_wr || sel_rd) begin
          if (hd_ill) begin
            rd_wr = sel_wr;
            rd_rd = sel_rd;
          end else if (acc) begin
            if (hd_len == '0) begin
              rd_wr     = sel_wr;
              rd_rd     = sel_rd;
              last_wr_d = !last_wr;
            end else begin
              addr_d     = next_addr(hd_addr, hd_size, hd_hburst);
              remain_d   = hd_len - LEN_W'(1);
              size_d     = hd_size;
              burst_d    = hd_hburst;
              state_next = sel_wr ? WR_ACT : RD_ACT;
            end
          end
        end
      end
      WR_ACT, RD_ACT: begin
        h_write = (state == WR_ACT);
        if (acc) begin
          addr_d   = next_addr(addr_q, size_q, burst_q);
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == '0) begin
            rd_wr      = (state == WR_ACT);
            rd_rd      = (state == RD_ACT);
            last_wr_d  = !last_wr;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pops are suppressed while reset is held so an abandoned burst keeps its head
  assign aw_fifo_rd = rd_wr & h_resetn;
  assign ar_fifo_rd = rd_rd & h_resetn;

endmodule
